// File: rtl/noc_output_port.sv
// Transmit side of a router-to-router link: local flit FIFO, credit-based flow control
// towards the neighbour input buffer, and wormhole framing tracking with sticky error flags.
module noc_output_port #(
   parameter int WIDTH     = 16,
   parameter int BUF_DEPTH = 4,
   parameter int CREDITS   = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [WIDTH-1:0]               data_i,
   input  logic                           push_i,
   output logic                           ready_o,
   output logic [WIDTH-1:0]               data_o,
   output logic                           write_en_o,
   input  logic                           credit_i,
   output logic [$clog2(CREDITS+1)-1:0]   credits_o,
   output logic                           locked_o,
   output logic                           proto_err_o,
   output logic                           credit_err_o
);

   localparam int PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int CW    = $clog2(CREDITS + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;
   typedef enum logic [1:0] {
      FT_BODY   = 2'b00,
      FT_TAIL   = 2'b01,
      FT_HEAD   = 2'b10,
      FT_SINGLE = 2'b11
   } ftype_t;

   logic [WIDTH-1:0] mem [BUF_DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CW-1:0]    credits, credits_next;
   logic             full, empty, push_ok, send, overflow;
   logic [WIDTH-1:0] head;
   ftype_t           head_type;
   state_t           state, state_next;
   logic             flit_err;

   assign full      = (count == CNT_W'(BUF_DEPTH));
   assign empty     = (count == '0);
   assign ready_o   = !full;
   assign push_ok   = push_i && ready_o;
   assign send      = !empty && (credits != '0);
   assign head      = mem[rd_ptr];
   assign head_type = ftype_t'(head[WIDTH-1 -: 2]);
   assign credits_o = credits;

   // NOTE: storage array carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= data_i;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (send)    rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         unique case ({push_ok, send})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // A credit arriving when the counter is already full is an error and is discarded.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      credits_next = credits;
      overflow     = 1'b0;
      if (send && !credit_i) begin
         credits_next = credits - CW'(1);
      end else if (!send && credit_i) begin
         if (credits == CW'(CREDITS)) overflow = 1'b1;
         else                         credits_next = credits + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits      <= CW'(CREDITS);
         credit_err_o <= 1'b0;
         data_o       <= '0;
         write_en_o   <= 1'b0;
         proto_err_o  <= 1'b0;
      end else begin
         credits    <= credits_next;
         write_en_o <= send;
         if (send)     data_o       <= head;
         if (overflow) credit_err_o <= 1'b1;
         if (flit_err) proto_err_o  <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Framing advances only on flits actually sent; bad flits are still transmitted.
   always_comb begin
      state_next = state;
      flit_err   = 1'b0;
      if (send) begin
         unique case (state)
            IDLE: begin
               if (head_type == FT_HEAD)        state_next = ACTIVE;
               else if (head_type != FT_SINGLE) flit_err   = 1'b1;
            end
            ACTIVE: begin
               if (head_type == FT_TAIL)        state_next = IDLE;
               else if (head_type != FT_BODY)   flit_err   = 1'b1;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      locked_o = (state == ACTIVE);
   end

endmodule

// File: tb/tb_noc_output_port.sv
// Self-checking bench for noc_output_port: scoreboard of expected downstream writes
// checked by a monitor, plus per-scenario checks of credits, ready and status flags.
module tb_noc_output_port;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_i;
   logic        push_i;
   logic        ready_o;
   logic [15:0] data_o;
   logic        write_en_o;
   logic        credit_i;
   logic [2:0]  credits_o;
   logic        locked_o;
   logic        proto_err_o;
   logic        credit_err_o;

   noc_output_port #(.WIDTH(16), .BUF_DEPTH(4), .CREDITS(5)) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .push_i(push_i), .ready_o(ready_o),
      .data_o(data_o), .write_en_o(write_en_o), .credit_i(credit_i), .credits_o(credits_o),
      .locked_o(locked_o), .proto_err_o(proto_err_o), .credit_err_o(credit_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        chk;
      logic        locked;
      logic        perr;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   write_cnt = 0;
   int   first_wr = -1;
   int   last_wr  = -1;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every downstream write must match the oldest expected flit.
   always @(negedge clk) begin
      if (!rst && write_en_o) begin
         exp_t e;
         write_cnt++;
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_write got=%h want=no write", data_o);
         end else begin
            e = exp_q.pop_front();
            if (data_o !== e.data) begin
               bad++;
               $display("FAIL sb_data got=%h want=%h", data_o, e.data);
            end
            if (e.chk) begin
               total++;
               if (locked_o !== e.locked || proto_err_o !== e.perr) begin
                  bad++;
                  $display("FAIL sb_flags data=%h got locked=%b perr=%b want locked=%b perr=%b",
                           e.data, locked_o, proto_err_o, e.locked, e.perr);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_flit(input logic [15:0] d, input logic chk, input logic lk, input logic pe);
      exp_t e;
      e.data = d; e.chk = chk; e.locked = lk; e.perr = pe;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      push_i = 1'b1; data_i = 16'hC0FF; expect_flit(16'hC0FF, 1'b0, 1'b0, 1'b0);
      cycle();
      push_i = 1'b0;
      cycle();
      total++;
      if (write_en_o !== 1'b1) begin bad++; $display("FAIL reset_pre_write got=%b want=1", write_en_o); end
      #5;
      rst = 1'b1;
      #1;
      total++;
      if (write_en_o !== 1'b0) begin bad++; $display("FAIL reset_write_en got=%b want=0", write_en_o); end
      total++;
      if (credits_o !== 3'd5) begin bad++; $display("FAIL reset_credits got=%0d want=5", credits_o); end
      total++;
      if (ready_o !== 1'b1 || locked_o !== 1'b0) begin
         bad++; $display("FAIL reset_ready_locked got=%b%b want=10", ready_o, locked_o);
      end
      total++;
      if (proto_err_o !== 1'b0 || credit_err_o !== 1'b0 || data_o !== 16'h0) begin
         bad++; $display("FAIL reset_errs_data got=%b%b %h want=00 0000", proto_err_o, credit_err_o, data_o);
      end
      cycle();
      rst = 1'b0;
      cycle();
   endtask

   task automatic test_credit_exhaustion();
      int w0;
      w0 = write_cnt; first_wr = -1;
      for (int i = 1; i <= 7; i++) begin
         push_i = 1'b1; data_i = 16'hC000 + 16'(i);
         if (i <= 5) expect_flit(data_i, 1'b0, 1'b0, 1'b0);
         cycle();
      end
      push_i = 1'b0;
      repeat (4) cycle();
      total++;
      if (write_cnt - w0 != 5) begin bad++; $display("FAIL exhaust_writes got=%0d want=5", write_cnt - w0); end
      total++;
      if (last_wr - first_wr != 4) begin bad++; $display("FAIL exhaust_consecutive got=%0d want=4", last_wr - first_wr); end
      total++;
      if (credits_o !== 3'd0 || write_en_o !== 1'b0) begin
         bad++; $display("FAIL exhaust_idle got credits=%0d we=%b want credits=0 we=0", credits_o, write_en_o);
      end
      credit_i = 1'b1; expect_flit(16'hC006, 1'b0, 1'b0, 1'b0);
      cycle();
      credit_i = 1'b0;
      cycle();
      total++;
      if (write_en_o !== 1'b1 || credits_o !== 3'd0) begin
         bad++; $display("FAIL credit_resume got we=%b credits=%0d want we=1 credits=0", write_en_o, credits_o);
      end
      cycle();
      total++;
      if (write_en_o !== 1'b0 || exp_q.size() != 0) begin
         bad++; $display("FAIL credit_resume_after got we=%b pending=%0d want we=0 pending=0", write_en_o, exp_q.size());
      end
   endtask

   task automatic test_fifo_full();
      int w0;
      expect_flit(16'hC007, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         push_i = 1'b1; data_i = 16'hD000 + 16'(i);
         if (i <= 3) expect_flit(data_i, 1'b0, 1'b0, 1'b0);
         cycle();
      end
      push_i = 1'b0;
      total++;
      if (ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", ready_o); end
      w0 = write_cnt;
      credit_i = 1'b1;
      repeat (4) cycle();
      credit_i = 1'b0;
      repeat (4) cycle();
      total++;
      if (write_cnt - w0 != 4 || exp_q.size() != 0) begin
         bad++; $display("FAIL full_drain got writes=%0d pending=%0d want writes=4 pending=0", write_cnt - w0, exp_q.size());
      end
      total++;
      if (credits_o !== 3'd0 || ready_o !== 1'b1) begin
         bad++; $display("FAIL full_after got credits=%0d ready=%b want credits=0 ready=1", credits_o, ready_o);
      end
   endtask

   task automatic test_back_to_back();
      credit_i = 1'b1;
      repeat (5) cycle();
      credit_i = 1'b0;
      cycle();
      total++;
      if (credits_o !== 3'd5) begin bad++; $display("FAIL b2b_refill got=%0d want=5", credits_o); end
      push_i = 1'b1; data_i = 16'hC100; expect_flit(data_i, 1'b0, 1'b0, 1'b0);
      cycle();
      for (int k = 1; k <= 8; k++) begin
         push_i = (k < 8);
         data_i = 16'hC100 + 16'(k);
         if (k < 8) expect_flit(data_i, 1'b0, 1'b0, 1'b0);
         credit_i = 1'b1;
         cycle();
         total++;
         if (write_en_o !== 1'b1 || credits_o !== 3'd5) begin
            bad++; $display("FAIL b2b_cycle%0d got we=%b credits=%0d want we=1 credits=5", k, write_en_o, credits_o);
         end
      end
      push_i = 1'b0; credit_i = 1'b0;
      cycle();
      total++;
      if (write_en_o !== 1'b0 || credits_o !== 3'd5) begin
         bad++; $display("FAIL b2b_end got we=%b credits=%0d want we=0 credits=5", write_en_o, credits_o);
      end
   endtask

   task automatic test_framing();
      logic [15:0] pkt [3];
      logic        lk  [3];
      pkt[0] = 16'h8000; pkt[1] = 16'h0011; pkt[2] = 16'h4022;
      lk[0]  = 1'b1;     lk[1]  = 1'b1;     lk[2]  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_i = 1'b1; data_i = pkt[i]; expect_flit(pkt[i], 1'b1, lk[i], 1'b0);
         cycle();
         if (i == 0) begin
            total++;
            if (locked_o !== 1'b0) begin bad++; $display("FAIL frame_prehead got=%b want=0", locked_o); end
         end
      end
      push_i = 1'b0;
      repeat (3) cycle();
      push_i = 1'b1; data_i = 16'h0033; expect_flit(16'h0033, 1'b1, 1'b0, 1'b1);
      cycle();
      push_i = 1'b0;
      repeat (3) cycle();
      total++;
      if (proto_err_o !== 1'b1 || locked_o !== 1'b0 || exp_q.size() != 0) begin
         bad++; $display("FAIL frame_end got perr=%b locked=%b pending=%0d want perr=1 locked=0 pending=0",
                         proto_err_o, locked_o, exp_q.size());
      end
      total++;
      if (credits_o !== 3'd1) begin bad++; $display("FAIL frame_credits got=%0d want=1", credits_o); end
   endtask

   task automatic test_credit_overflow();
      credit_i = 1'b1;
      repeat (4) cycle();
      credit_i = 1'b0;
      cycle();
      total++;
      if (credits_o !== 3'd5 || credit_err_o !== 1'b0) begin
         bad++; $display("FAIL ovf_pre got credits=%0d cerr=%b want credits=5 cerr=0", credits_o, credit_err_o);
      end
      credit_i = 1'b1;
      cycle();
      credit_i = 1'b0;
      total++;
      if (credit_err_o !== 1'b1 || credits_o !== 3'd5) begin
         bad++; $display("FAIL ovf_flag got cerr=%b credits=%0d want cerr=1 credits=5", credit_err_o, credits_o);
      end
      repeat (3) cycle();
      total++;
      if (credit_err_o !== 1'b1 || proto_err_o !== 1'b1 || credits_o !== 3'd5) begin
         bad++; $display("FAIL ovf_sticky got cerr=%b perr=%b credits=%0d want 1 1 5", credit_err_o, proto_err_o, credits_o);
      end
   endtask

   initial begin
      rst = 1'b1; push_i = 1'b0; data_i = '0; credit_i = 1'b0;
      #1;
      repeat (2) cycle();
      rst = 1'b0;
      cycle();
      test_reset();
      test_credit_exhaustion();
      test_fifo_full();
      test_back_to_back();
      test_framing();
      test_credit_overflow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
